debounce_bank: RTL and testbench

Parametrised N-channel switch debouncer for the board's push-button and slide-switch inputs. Each channel synchronises a raw pin, filters contact bounce with a stable-count window, and produces a clean level, one-cycle press/release pulses, a press-toggled latch, and a one-shot long-press pulse. It sits between the top-level pins and the user logic, and replaces per-switch single-purpose debouncer instances.

---
 rtl/debounce_bank_if.sv | 23 ++
 rtl/debounce_bank.sv | 116 +++++++++++
 tb/tb_debounce_bank.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/debounce_bank_if.sv
// Pin-side and user-side signals of the debouncer bank, one bit per channel.
// master drives the raw pins; slave is the debouncer itself.
interface debounce_bank_if #(
    parameter int N = 4
);
    logic [N-1:0] sw_in;
    logic [N-1:0] state;
    logic [N-1:0] pressed;
    logic [N-1:0] trans_press;
    logic [N-1:0] trans_release;
    logic [N-1:0] toggle;
    logic [N-1:0] long_press;

    modport master (
        output sw_in,
        input  state, pressed, trans_press, trans_release, toggle, long_press
    );

    modport slave (
        input  sw_in,
        output state, pressed, trans_press, trans_release, toggle, long_press
    );
endinterface

// File: rtl/debounce_bank.sv
// N-channel switch debouncer: 2-flop synchroniser, stable-count filter,
// press/release pulses, press-toggled latch and one-shot long-press pulse.
module debounce_lane #(
    parameter int STABLE_CYCLES = 50000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int PRESS_LEVEL   = 0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic sw_in,
    output logic state,
    output logic pressed,
    output logic trans_press,
    output logic trans_release,
    output logic toggle,
    output logic long_press
);
    localparam int CW = $clog2(STABLE_CYCLES);
    // A zero-width hold counter is not legal, so the disabled case keeps one idle bit.
    localparam int HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
    localparam logic PL  = (PRESS_LEVEL != 0);
    localparam logic REL = ~PL;
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic [HW-1:0] hold;
    logic          accept;

    assign accept  = (sync2 != state) && (cnt == CNT_MAX);
    assign pressed = (state == PL);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1         <= REL;
            sync2         <= REL;
            state         <= REL;
            cnt           <= '0;
            hold          <= '0;
            toggle        <= 1'b0;
            trans_press   <= 1'b0;
            trans_release <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            sync1         <= sw_in;
            sync2         <= sync1;
            trans_press   <= 1'b0;
            trans_release <= 1'b0;
            long_press    <= 1'b0;

            if (sync2 == state) begin
                cnt <= '0;
            end else if (accept) begin
                state <= sync2;
                cnt   <= '0;
                if (sync2 == PL) begin
                    trans_press <= 1'b1;
                    toggle      <= ~toggle;
                end else begin
                    trans_release <= 1'b1;
                end
            end else begin
                cnt <= cnt + CNT_ONE;
            end

            // An accepted release on the firing edge clears hold first, so it beats long_press.
            if (accept || (state != PL)) begin
                hold <= '0;
            end else if (hold != HOLD_MAX) begin
                hold       <= hold + HOLD_ONE;
                long_press <= ((hold + HOLD_ONE) == HOLD_MAX);
            end
        end
    end
endmodule

module debounce_bank #(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = 50000,
    parameter int LONG_CYCLES   = 12000000,
    parameter int PRESS_LEVEL   = 0
) (
    input  logic            CLK,
    input  logic            RESET,
    debounce_bank_if.slave  bus
);
    logic [N-1:0] state_w, pressed_w, tp_w, tr_w, tg_w, lp_w;

    for (genvar g = 0; g < N; g++) begin : g_lane
        debounce_lane #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .LONG_CYCLES   (LONG_CYCLES),
            .PRESS_LEVEL   (PRESS_LEVEL)
        ) u_lane (
            .CLK           (CLK),
            .RESET         (RESET),
            .sw_in         (bus.sw_in[g]),
            .state         (state_w[g]),
            .pressed       (pressed_w[g]),
            .trans_press   (tp_w[g]),
            .trans_release (tr_w[g]),
            .toggle        (tg_w[g]),
            .long_press    (lp_w[g])
        );
    end

    assign bus.state         = state_w;
    assign bus.pressed       = pressed_w;
    assign bus.trans_press   = tp_w;
    assign bus.trans_release = tr_w;
    assign bus.toggle        = tg_w;
    assign bus.long_press    = lp_w;
endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed vector table on an active-low instance,
// plus randomized pins checked against a sample-window reference model on two instances.
module tb_debounce_bank;
    localparam int N = 4;
    localparam int S = 4;
    localparam int PLV [2] = '{0, 1};
    localparam int LNG [2] = '{10, 0};

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic [N-1:0] sw = '1;

    always #5 CLK = ~CLK;

    debounce_bank_if #(.N(N)) bus_a ();
    debounce_bank_if #(.N(N)) bus_b ();
    assign bus_a.sw_in = sw;
    assign bus_b.sw_in = sw;

    debounce_bank #(.N(N), .STABLE_CYCLES(S), .LONG_CYCLES(10), .PRESS_LEVEL(0))
        dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a));
    debounce_bank #(.N(N), .STABLE_CYCLES(S), .LONG_CYCLES(0), .PRESS_LEVEL(1))
        dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    // Reference model: a channel accepts a new level once the last S synchronised
    // samples (pin samples two edges old) all differ from it, at least S edges after
    // the previous acceptance or reset.
    logic [N-1:0] hist [2][8192];
    int ec = 4;
    bit ms [2][N];
    bit mtg [2][N];
    int mla [2][N];
    int mtp [2][N];
    logic [N-1:0] e_st [2], e_pr [2], e_tp [2], e_tr [2], e_tg [2], e_lp [2];

    task automatic model_step(input logic r, input logic [N-1:0] s);
        ec++;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N; c++) begin
                bit pl;
                bit acc;
                pl = (PLV[k] != 0);
                e_tp[k][c] = 1'b0;
                e_tr[k][c] = 1'b0;
                e_lp[k][c] = 1'b0;
                if (r) begin
                    hist[k][ec][c]   = !pl;
                    hist[k][ec-1][c] = !pl;
                    ms[k][c]  = !pl;
                    mla[k][c] = ec;
                    mtg[k][c] = 1'b0;
                end else begin
                    hist[k][ec][c] = s[c];
                    acc = (ec - mla[k][c] >= S);
                    for (int j = 2; j <= S + 1; j++)
                        if (hist[k][ec-j][c] == ms[k][c]) acc = 1'b0;
                    if (acc) begin
                        ms[k][c]  = !ms[k][c];
                        mla[k][c] = ec;
                        if (ms[k][c] == pl) begin
                            e_tp[k][c] = 1'b1;
                            mtg[k][c]  = !mtg[k][c];
                            mtp[k][c]  = ec;
                        end else begin
                            e_tr[k][c] = 1'b1;
                        end
                    end else if (ms[k][c] == pl && LNG[k] > 0 && ec - mtp[k][c] == LNG[k]) begin
                        e_lp[k][c] = 1'b1;
                    end
                end
                e_st[k][c] = ms[k][c];
                e_pr[k][c] = (ms[k][c] == pl);
                e_tg[k][c] = mtg[k][c];
            end
        end
    endtask

    task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b want=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("a.state",   bus_a.state,         e_st[0]);
        cmp("a.pressed", bus_a.pressed,       e_pr[0]);
        cmp("a.tpress",  bus_a.trans_press,   e_tp[0]);
        cmp("a.trel",    bus_a.trans_release, e_tr[0]);
        cmp("a.toggle",  bus_a.toggle,        e_tg[0]);
        cmp("a.long",    bus_a.long_press,    e_lp[0]);
        cmp("b.state",   bus_b.state,         e_st[1]);
        cmp("b.pressed", bus_b.pressed,       e_pr[1]);
        cmp("b.tpress",  bus_b.trans_press,   e_tp[1]);
        cmp("b.trel",    bus_b.trans_release, e_tr[1]);
        cmp("b.toggle",  bus_b.toggle,        e_tg[1]);
        cmp("b.long",    bus_b.long_press,    e_lp[1]);
    endtask

    task automatic step(input logic r, input logic [N-1:0] s);
        RESET = r;
        sw    = s;
        @(posedge CLK);
        model_step(r, s);
        #1;
        check_model();
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] sw;
        int           n;
        logic [N-1:0] st, tp, tr, tg, lp;
    } vec_t;

    vec_t tbl [$];

    initial begin
        // Expected outputs of the active-low instance, held for every edge of a row.
        tbl.push_back('{1'b1, 4'b1111,  2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000}); // reset
        tbl.push_back('{1'b0, 4'b1110,  5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000}); // press, latency
        tbl.push_back('{1'b0, 4'b1110,  1, 4'b1110, 4'b0001, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  2, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  5, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000}); // release
        tbl.push_back('{1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  3, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  3, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000}); // bounce
        tbl.push_back('{1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  3, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  4, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  5, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000}); // second press
        tbl.push_back('{1'b0, 4'b1110,  1, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  9, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000}); // long hold
        tbl.push_back('{1'b0, 4'b1110,  1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0001});
        tbl.push_back('{1'b0, 4'b1110, 12, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  5, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000}); // release on firing edge
        tbl.push_back('{1'b0, 4'b1110,  1, 4'b1110, 4'b0001, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  4, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  5, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0001, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 12, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1100,  5, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000}); // simultaneous
        tbl.push_back('{1'b0, 4'b1100,  1, 4'b1100, 4'b0011, 4'b0000, 4'b0010, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  5, 4'b1100, 4'b0000, 4'b0000, 4'b0010, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  1, 4'b1111, 4'b0000, 4'b0011, 4'b0010, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111,  2, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  4, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000}); // count reaches 2
        tbl.push_back('{1'b1, 4'b1110,  1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000}); // reset mid-count
        tbl.push_back('{1'b0, 4'b1110,  5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  1, 4'b1110, 4'b0001, 4'b0000, 4'b0001, 4'b0000});
        tbl.push_back('{1'b0, 4'b1110,  3, 4'b1110, 4'b0000, 4'b0000, 4'b0001, 4'b0000});

        foreach (tbl[i]) begin
            for (int e = 0; e < tbl[i].n; e++) begin
                step(tbl[i].rst, tbl[i].sw);
                cmp($sformatf("row%0d.state", i),   bus_a.state,         tbl[i].st);
                cmp($sformatf("row%0d.pressed", i), bus_a.pressed,       ~tbl[i].st);
                cmp($sformatf("row%0d.tpress", i),  bus_a.trans_press,   tbl[i].tp);
                cmp($sformatf("row%0d.trel", i),    bus_a.trans_release, tbl[i].tr);
                cmp($sformatf("row%0d.toggle", i),  bus_a.toggle,        tbl[i].tg);
                cmp($sformatf("row%0d.long", i),    bus_a.long_press,    tbl[i].lp);
            end
        end

        // Random pins with varying bounce density and occasional resets.
        begin
            logic [N-1:0] pins;
            int rate;
            int rst_left;
            pins = sw;
            rate = 2;
            rst_left = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (cyc % 250 == 0) begin
                    case ($urandom_range(0, 2))
                        0: rate = 1;
                        1: rate = 8;
                        default: rate = 35;
                    endcase
                end
                for (int c = 0; c < N; c++)
                    if ($urandom_range(0, 99) < rate) pins[c] = ~pins[c];
                if (rst_left == 0 && $urandom_range(0, 399) == 0)
                    rst_left = $urandom_range(1, 2);
                step(rst_left != 0, pins);
                if (rst_left != 0) rst_left--;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
